mem_port_arbiter: RTL and testbench

Sequencing arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch (IF) stage and its data-memory (MEM) stage. It accepts held-until-acknowledged requests from both stages and issues exactly one memory transaction at a time. It returns read data and a one-cycle acknowledge to the winning requester, and drives per-stage stall signals consumed by the PC/IFID and EX/MEM pipeline registers.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the data port always wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic                w_capture;
  logic                w_pick_dm;

  logic                r_owner_dm;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_if_ack;
  logic                r_dm_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

`ifdef ARB_RR_EN
  logic                r_last_dm;

  // Ties go to whichever port did not own the previous grant.
  assign w_pick_dm = dm_req_i & (~if_req_i | ~r_last_dm);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_last_dm <= 1'b0;
    end else if (w_load) begin
      r_last_dm <= w_pick_dm;
    end else begin
      r_last_dm <= r_last_dm;
    end
  end
`else
  assign w_pick_dm = dm_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req_i || dm_req_i) begin
          w_state_nxt = S_GRANT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (mem_ack_i) begin
          w_state_nxt = S_RESP;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Fetch transactions never write, so their we/wdata are forced low at latch time.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_owner_dm  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      if (w_load) begin
        r_owner_dm  <= w_pick_dm;
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_pick_dm & dm_we_i;
        r_mem_addr  <= w_pick_dm ? dm_addr_i : if_addr_i;
        r_mem_wdata <= w_pick_dm ? dm_wdata_i : '0;
      end else if (w_capture) begin
        r_mem_req <= 1'b0;
        if (r_owner_dm) begin
          r_dm_ack <= 1'b1;
          if (!r_mem_we) begin
            r_dm_rdata <= mem_rdata_i;
          end else begin
            r_dm_rdata <= r_dm_rdata;
          end
        end else begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= mem_rdata_i;
        end
      end else begin
        r_mem_req <= r_mem_req;
      end
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign if_ack_o    = r_if_ack;
  assign dm_ack_o    = r_dm_ack;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign if_stall_o  = if_req_i & ~r_if_ack;
  assign dm_stall_o  = dm_req_i & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; tie-order expectations follow ARB_RR_EN.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        if_stall_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Memory completes lat cycles after mem_req_o rose; returns just after the ack edge.
  task automatic respond(input int lat, input logic [31:0] data);
    repeat (lat - 1) step();
    mem_rdata_i = data;
    mem_ack_i   = 1'b1;
    step();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  initial begin
    logic exp_dm;
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    step(); step();
    check_eq("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check_eq("rst_acks", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
    check_eq("rst_mem_addr", mem_addr_o, 32'h0);
    check_eq("rst_if_rdata", if_rdata_o, 32'h0);
    rst_i = 1'b1;
    step();

    // Single fetch, memory latency 2
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    step();
    check_eq("fetch_mem_req", {31'd0, mem_req_o}, 32'd1);
    check_eq("fetch_mem_addr", mem_addr_o, 32'h0000_0010);
    check_eq("fetch_mem_we", {31'd0, mem_we_o}, 32'd0);
    check_eq("fetch_stall_wait", {31'd0, if_stall_o}, 32'd1);
    respond(2, 32'h0000_0513);
    check_eq("fetch_if_ack", {31'd0, if_ack_o}, 32'd1);
    check_eq("fetch_dm_ack", {31'd0, dm_ack_o}, 32'd0);
    check_eq("fetch_if_rdata", if_rdata_o, 32'h0000_0513);
    check_eq("fetch_stall_ack", {31'd0, if_stall_o}, 32'd0);
    check_eq("fetch_req_drop", {31'd0, mem_req_o}, 32'd0);
    step();
    check_eq("fetch_ack_pulse", {31'd0, if_ack_o}, 32'd0);
    if_req_i = 1'b0;

    // Simultaneous requests: data load wins, fetch follows
    if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0200;
    step();
    check_eq("tie_first_addr", mem_addr_o, 32'h0000_0200);
    respond(1, 32'h0000_AAAA);
    check_eq("tie_acks_1", {30'd0, if_ack_o, dm_ack_o}, 32'd1);
    check_eq("tie_dm_rdata", dm_rdata_o, 32'h0000_AAAA);
    check_eq("tie_stalls_1", {30'd0, if_stall_o, dm_stall_o}, 32'd2);
    step();
    dm_req_i = 1'b0;
    step();
    check_eq("tie_second_addr", mem_addr_o, 32'h0000_0020);
    respond(1, 32'h0000_BBBB);
    check_eq("tie_acks_2", {30'd0, if_ack_o, dm_ack_o}, 32'd2);
    check_eq("tie_if_rdata", if_rdata_o, 32'h0000_BBBB);
    check_eq("tie_dm_hold", dm_rdata_o, 32'h0000_AAAA);
    step();
    if_req_i = 1'b0;

    // Store leaves dm_rdata_o untouched
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0000_0100; dm_wdata_i = 32'hDEAD_BEEF;
    step();
    check_eq("st_mem_we", {31'd0, mem_we_o}, 32'd1);
    check_eq("st_mem_addr", mem_addr_o, 32'h0000_0100);
    check_eq("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    respond(1, 32'h1234_5678);
    check_eq("st_dm_ack", {31'd0, dm_ack_o}, 32'd1);
    check_eq("st_dm_rdata", dm_rdata_o, 32'h0000_AAAA);
    step();
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_wdata_i = 32'h0;

    // Spurious memory ack while idle
    mem_rdata_i = 32'h5555_5555; mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    check_eq("spur_acks", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
    check_eq("spur_mem_req", {31'd0, mem_req_o}, 32'd0);
    step();
    check_eq("spur_acks_late", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
    check_eq("spur_if_rdata", if_rdata_o, 32'h0000_BBBB);
    check_eq("spur_dm_rdata", dm_rdata_o, 32'h0000_AAAA);
    if_req_i = 1'b1; if_addr_i = 32'h0000_0044;
    step();
    check_eq("spur_then_req", mem_addr_o, 32'h0000_0044);

    // Reset while waiting on the memory, then re-grant
    step();
    rst_i = 1'b0;
    step();
    check_eq("rstm_mem_req", {31'd0, mem_req_o}, 32'd0);
    check_eq("rstm_acks", {30'd0, if_ack_o, dm_ack_o}, 32'd0);
    check_eq("rstm_mem_addr", mem_addr_o, 32'h0);
    check_eq("rstm_if_rdata", if_rdata_o, 32'h0);
    check_eq("rstm_dm_rdata", dm_rdata_o, 32'h0);
    rst_i = 1'b1;
    step();
    check_eq("rstm_regrant", {31'd0, mem_req_o}, 32'd1);
    check_eq("rstm_regrant_addr", mem_addr_o, 32'h0000_0044);
    respond(3, 32'h0000_0077);
    check_eq("rstm_if_ack", {31'd0, if_ack_o}, 32'd1);
    check_eq("rstm_if_rdata2", if_rdata_o, 32'h0000_0077);
    step();
    if_req_i = 1'b0;

    // Both requests held across four transactions
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0030;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_dm = (k % 2 == 0);
`else
      exp_dm = 1'b1;
`endif
      step();
      check_eq($sformatf("hold_addr_%0d", k), mem_addr_o, exp_dm ? 32'h0000_0300 : 32'h0000_0030);
      respond(1, 32'h0000_1000 + k);
      check_eq($sformatf("hold_acks_%0d", k), {30'd0, if_ack_o, dm_ack_o}, exp_dm ? 32'd1 : 32'd2);
      check_eq($sformatf("hold_rdata_%0d", k), exp_dm ? dm_rdata_o : if_rdata_o, 32'h0000_1000 + k);
      step();
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    step();
    check_eq("end_idle", {31'd0, mem_req_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
